crossbar_one_hot_pipe: RTL

- Parametrised NUM_INPUT_DATA x NUM_OUTPUT_DATA one-hot crossbar with a programmable pipeline depth and a shadow command register.
- Adds per-output conflict detection with priority resolution, stall via i_en, and a sticky error flag.
- Sits between the input distribution network and the output consumers. Generalised replacement for the fixed 8x8 sequential crossbar.

---
 rtl/crossbar_one_hot_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/crossbar_one_hot_pipe.sv
`default_nettype none
// ============================================================================
// Module      : crossbar_one_hot_pipe
// Description : NUM_INPUT_DATA x NUM_OUTPUT_DATA one-hot crossbar with shadow
//               command register, per-output conflict resolution (lowest input
//               wins), PIPE_STAGES-deep stallable pipeline and sticky error.
//               Optional macro XBAR_CONFLICT_CNT_EN adds o_conflict_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module crossbar_one_hot_pipe #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_INPUT_DATA  = 8,
    parameter int NUM_OUTPUT_DATA = 8,
    parameter int PIPE_STAGES     = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_INPUT_DATA-1:0]             i_valid,
    input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]  i_data_bus,
    input  logic                                  i_en,
    input  logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] i_cmd,
    input  logic                                  i_cmd_load,
    input  logic                                  i_err_clr,
    output logic [NUM_OUTPUT_DATA-1:0]            o_valid,
    output logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] o_data_bus,
    output logic [NUM_OUTPUT_DATA-1:0]            o_conflict,
    output logic                                  o_err
`ifdef XBAR_CONFLICT_CNT_EN
    ,
    output logic [15:0]                           o_conflict_cnt
`endif
);

    localparam int c_CMD_W  = NUM_INPUT_DATA * NUM_OUTPUT_DATA;
    localparam int c_OBUS_W = NUM_OUTPUT_DATA * DATA_WIDTH;

    logic [c_CMD_W-1:0]         r_cmd_q;
    logic [c_CMD_W-1:0]         w_cmd_d;
    logic [NUM_OUTPUT_DATA-1:0] w_res_valid;
    logic [NUM_OUTPUT_DATA-1:0] w_res_conf;
    logic [c_OBUS_W-1:0]        w_res_data;

    logic [NUM_OUTPUT_DATA-1:0] r_valid_q [PIPE_STAGES];
    logic [NUM_OUTPUT_DATA-1:0] w_valid_d [PIPE_STAGES];
    logic [NUM_OUTPUT_DATA-1:0] r_conf_q  [PIPE_STAGES];
    logic [NUM_OUTPUT_DATA-1:0] w_conf_d  [PIPE_STAGES];
    logic [c_OBUS_W-1:0]        r_data_q  [PIPE_STAGES];
    logic [c_OBUS_W-1:0]        w_data_d  [PIPE_STAGES];

    logic r_err_q;
    logic w_err_d;

    // The next shadow value doubles as the effective command for this cycle.
    assign w_cmd_d = i_cmd_load ? i_cmd : r_cmd_q;

    generate
        for (genvar go = 0; go < NUM_OUTPUT_DATA; go++) begin : g_out
            logic                  w_hit;
            logic                  w_multi;
            logic                  w_sel_valid;
            logic [DATA_WIDTH-1:0] w_sel_data;

            // Scan high-to-low so the lowest set input is the last one kept.
            always_comb begin
                w_hit       = 1'b0;
                w_multi     = 1'b0;
                w_sel_valid = 1'b0;
                w_sel_data  = '0;
                for (int i = NUM_INPUT_DATA - 1; i >= 0; i--) begin
                    if (w_cmd_d[i*NUM_OUTPUT_DATA+go]) begin
                        w_multi     = w_multi | w_hit;
                        w_hit       = 1'b1;
                        w_sel_valid = i_valid[i];
                        w_sel_data  = i_data_bus[i*DATA_WIDTH+:DATA_WIDTH];
                    end
                end
            end

            assign w_res_valid[go]                       = w_sel_valid;
            assign w_res_conf[go]                        = w_multi;
            assign w_res_data[go*DATA_WIDTH+:DATA_WIDTH] = w_sel_valid ? w_sel_data : '0;
        end
    endgenerate

    always_comb begin
        for (int s = 0; s < PIPE_STAGES; s++) begin
            w_valid_d[s] = r_valid_q[s];
            w_conf_d[s]  = r_conf_q[s];
            w_data_d[s]  = r_data_q[s];
        end
        if (i_en) begin
            w_valid_d[0] = w_res_valid;
            w_conf_d[0]  = w_res_conf;
            w_data_d[0]  = w_res_data;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                w_valid_d[s] = r_valid_q[s-1];
                w_conf_d[s]  = r_conf_q[s-1];
                w_data_d[s]  = r_data_q[s-1];
            end
        end
    end

    // A conflict entering stage 1 beats a simultaneous clear.
    assign w_err_d = (i_en && (|w_res_conf)) ? 1'b1 : (i_err_clr ? 1'b0 : r_err_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_q <= '0;
            r_err_q <= 1'b0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_valid_q[s] <= '0;
                r_conf_q[s]  <= '0;
                r_data_q[s]  <= '0;
            end
        end else begin
            r_cmd_q <= w_cmd_d;
            r_err_q <= w_err_d;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_valid_q[s] <= w_valid_d[s];
                r_conf_q[s]  <= w_conf_d[s];
                r_data_q[s]  <= w_data_d[s];
            end
        end
    end

    assign o_valid    = r_valid_q[PIPE_STAGES-1];
    assign o_conflict = r_conf_q[PIPE_STAGES-1];
    assign o_data_bus = r_data_q[PIPE_STAGES-1];
    assign o_err      = r_err_q;

`ifdef XBAR_CONFLICT_CNT_EN
    logic [15:0] r_cnt_q;
    logic [15:0] w_cnt_d;

    // Clear first, then increment, so clear plus increment yields 1.
    always_comb begin
        w_cnt_d = i_err_clr ? 16'd0 : r_cnt_q;
        if (i_en && (|w_res_conf) && (w_cnt_d != 16'hFFFF)) begin
            w_cnt_d = w_cnt_d + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_conflict_cnt = r_cnt_q;
`endif

endmodule
`default_nettype wire
